// File: rtl/computation_memory.sv
// computation_memory: operand holding register bank for the convolution
// datapath. Captures a 4x4 A tile and a 3x3 B kernel in one edge on an
// activate request and holds them stable until the next request.
module computation_memory (
    input  logic       clk,
    input  logic       rst,
    input  logic       activate,
    input  logic [7:0] a11_in, a12_in, a13_in, a14_in,
    input  logic [7:0] a21_in, a22_in, a23_in, a24_in,
    input  logic [7:0] a31_in, a32_in, a33_in, a34_in,
    input  logic [7:0] a41_in, a42_in, a43_in, a44_in,
    input  logic [7:0] b11_in, b12_in, b13_in,
    input  logic [7:0] b21_in, b22_in, b23_in,
    input  logic [7:0] b31_in, b32_in, b33_in,
    output logic       activate_done,
    output logic [7:0] a11, a12, a13, a14,
    output logic [7:0] a21, a22, a23, a24,
    output logic [7:0] a31, a32, a33, a34,
    output logic [7:0] a41, a42, a43, a44,
    output logic [7:0] b11, b12, b13,
    output logic [7:0] b21, b22, b23,
    output logic [7:0] b31, b32, b33
);

    typedef enum logic {IDLE, DONE} state_t;

    state_t     r_state;
    logic       r_done;
    logic [7:0] r_a [16];
    logic [7:0] r_b [9];
    logic [7:0] w_a_in [16];
    logic [7:0] w_b_in [9];

    // Gather the individual operand ports into row-major arrays.
    assign w_a_in[0]  = a11_in;  assign w_a_in[1]  = a12_in;
    assign w_a_in[2]  = a13_in;  assign w_a_in[3]  = a14_in;
    assign w_a_in[4]  = a21_in;  assign w_a_in[5]  = a22_in;
    assign w_a_in[6]  = a23_in;  assign w_a_in[7]  = a24_in;
    assign w_a_in[8]  = a31_in;  assign w_a_in[9]  = a32_in;
    assign w_a_in[10] = a33_in;  assign w_a_in[11] = a34_in;
    assign w_a_in[12] = a41_in;  assign w_a_in[13] = a42_in;
    assign w_a_in[14] = a43_in;  assign w_a_in[15] = a44_in;
    assign w_b_in[0]  = b11_in;  assign w_b_in[1]  = b12_in;
    assign w_b_in[2]  = b13_in;  assign w_b_in[3]  = b21_in;
    assign w_b_in[4]  = b22_in;  assign w_b_in[5]  = b23_in;
    assign w_b_in[6]  = b31_in;  assign w_b_in[7]  = b32_in;
    assign w_b_in[8]  = b33_in;

    // Capture FSM: load on the first activate edge in IDLE, then freeze
    // until activate is seen low, which re-arms without clearing data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) r_a[i] <= 8'h00;
            for (int i = 0; i < 9; i++)  r_b[i] <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (activate) begin
                        for (int i = 0; i < 16; i++) r_a[i] <= w_a_in[i];
                        for (int i = 0; i < 9; i++)  r_b[i] <= w_b_in[i];
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!activate) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the output ports straight from the holding registers.
    assign activate_done = r_done;
    assign a11 = r_a[0];   assign a12 = r_a[1];
    assign a13 = r_a[2];   assign a14 = r_a[3];
    assign a21 = r_a[4];   assign a22 = r_a[5];
    assign a23 = r_a[6];   assign a24 = r_a[7];
    assign a31 = r_a[8];   assign a32 = r_a[9];
    assign a33 = r_a[10];  assign a34 = r_a[11];
    assign a41 = r_a[12];  assign a42 = r_a[13];
    assign a43 = r_a[14];  assign a44 = r_a[15];
    assign b11 = r_b[0];   assign b12 = r_b[1];
    assign b13 = r_b[2];   assign b21 = r_b[3];
    assign b22 = r_b[4];   assign b23 = r_b[5];
    assign b31 = r_b[6];   assign b32 = r_b[7];
    assign b33 = r_b[8];

endmodule

// File: tb/tb_computation_memory.sv
// Testbench for computation_memory: scoreboard of expected register
// contents built from a behavioural model of the capture protocol.
module tb_computation_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       activate = 1'b0;
    logic [7:0] ia [16];
    logic [7:0] ib [9];
    logic [7:0] oa [16];
    logic [7:0] ob [9];
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic            done;
        logic [15:0][7:0] a;
        logic [8:0][7:0]  b;
    } exp_t;

    exp_t q[$];

    // behavioural model state
    logic       m_busy;
    logic       m_done;
    logic [7:0] m_a [16];
    logic [7:0] m_b [9];

    always #5 clk = ~clk;

    computation_memory dut (
        .clk(clk), .rst(rst), .activate(activate),
        .a11_in(ia[0]),  .a12_in(ia[1]),  .a13_in(ia[2]),  .a14_in(ia[3]),
        .a21_in(ia[4]),  .a22_in(ia[5]),  .a23_in(ia[6]),  .a24_in(ia[7]),
        .a31_in(ia[8]),  .a32_in(ia[9]),  .a33_in(ia[10]), .a34_in(ia[11]),
        .a41_in(ia[12]), .a42_in(ia[13]), .a43_in(ia[14]), .a44_in(ia[15]),
        .b11_in(ib[0]),  .b12_in(ib[1]),  .b13_in(ib[2]),
        .b21_in(ib[3]),  .b22_in(ib[4]),  .b23_in(ib[5]),
        .b31_in(ib[6]),  .b32_in(ib[7]),  .b33_in(ib[8]),
        .activate_done(done),
        .a11(oa[0]),  .a12(oa[1]),  .a13(oa[2]),  .a14(oa[3]),
        .a21(oa[4]),  .a22(oa[5]),  .a23(oa[6]),  .a24(oa[7]),
        .a31(oa[8]),  .a32(oa[9]),  .a33(oa[10]), .a34(oa[11]),
        .a41(oa[12]), .a42(oa[13]), .a43(oa[14]), .a44(oa[15]),
        .b11(ob[0]),  .b12(ob[1]),  .b13(ob[2]),
        .b21(ob[3]),  .b22(ob[4]),  .b23(ob[5]),
        .b31(ob[6]),  .b32(ob[7]),  .b33(ob[8])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        for (int i = 0; i < 16; i++) m_a[i] = 8'h00;
        for (int i = 0; i < 9; i++)  m_b[i] = 8'h00;
    endtask

    task automatic set_rows(input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input logic [7:0] r4,
                            input logic [7:0] k1, input logic [7:0] k2,
                            input logic [7:0] k3);
        for (int c = 0; c < 4; c++) begin
            ia[c] = r1; ia[4+c] = r2; ia[8+c] = r3; ia[12+c] = r4;
        end
        for (int c = 0; c < 3; c++) begin
            ib[c] = k1; ib[3+c] = k2; ib[6+c] = k3;
        end
    endtask

    task automatic set_all(input logic [7:0] va, input logic [7:0] vb);
        for (int i = 0; i < 16; i++) ia[i] = va;
        for (int i = 0; i < 9; i++)  ib[i] = vb;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) ia[i] = 8'($urandom);
        for (int i = 0; i < 9; i++)  ib[i] = 8'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".done"}, {7'b0, done}, 8'h00);
        for (int i = 0; i < 16; i++) chk($sformatf("%s.a[%0d]", tag, i), oa[i], 8'h00);
        for (int i = 0; i < 9; i++)  chk($sformatf("%s.b[%0d]", tag, i), ob[i], 8'h00);
    endtask

    // Drive activate for one edge: predict, push, clock, pop and compare.
    task automatic cycle(input logic act);
        exp_t e;
        activate = act;
        if (!m_busy && act) begin
            for (int i = 0; i < 16; i++) m_a[i] = ia[i];
            for (int i = 0; i < 9; i++)  m_b[i] = ib[i];
            m_done = 1'b1;
            m_busy = 1'b1;
        end else if (m_busy && !act) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end
        e.done = m_done;
        for (int i = 0; i < 16; i++) e.a[i] = m_a[i];
        for (int i = 0; i < 9; i++)  e.b[i] = m_b[i];
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = q.pop_front();
            chk("done", {7'b0, done}, {7'b0, e.done});
            for (int i = 0; i < 16; i++) chk($sformatf("a[%0d]", i), oa[i], e.a[i]);
            for (int i = 0; i < 9; i++)  chk($sformatf("b[%0d]", i), ob[i], e.b[i]);
        end
    endtask

    task automatic check_rows(input string tag,
                              input logic [7:0] r1, input logic [7:0] r2,
                              input logic [7:0] r3, input logic [7:0] r4,
                              input logic [7:0] k1, input logic [7:0] k2,
                              input logic [7:0] k3);
        chk({tag, ".a11"}, oa[0], r1);
        chk({tag, ".a24"}, oa[7], r2);
        chk({tag, ".a32"}, oa[9], r3);
        chk({tag, ".a44"}, oa[15], r4);
        chk({tag, ".b13"}, ob[2], k1);
        chk({tag, ".b21"}, ob[3], k2);
        chk({tag, ".b33"}, ob[8], k3);
    endtask

    initial begin
        model_reset();
        // Reset held with random data and activate high: nothing captured.
        rst = 1'b0;
        activate = 1'b1;
        set_random();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        // Release with activate high: capture on first edge after release.
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1);
        chk("post_rst_done", {7'b0, done}, 8'h01);
        cycle(1'b0);

        // Basic capture, data presented one cycle ahead.
        set_rows(8'd3, 8'd4, 8'd9, 8'd14, 8'd11, 8'd2, 8'd9);
        cycle(1'b0);
        cycle(1'b1);
        check_rows("basic", 8'd3, 8'd4, 8'd9, 8'd14, 8'd11, 8'd2, 8'd9);
        chk("basic.done", {7'b0, done}, 8'h01);

        // Hold while active: inputs change, outputs frozen.
        set_all(8'hFF, 8'hFF);
        cycle(1'b1);
        cycle(1'b1);
        check_rows("hold", 8'd3, 8'd4, 8'd9, 8'd14, 8'd11, 8'd2, 8'd9);
        chk("hold.done", {7'b0, done}, 8'h01);

        // Reset mid-request: half-cycle pulse clears immediately.
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        set_rows(8'd3, 8'd4, 8'd9, 8'd14, 8'd11, 8'd2, 8'd9);
        cycle(1'b0);
        cycle(1'b1);
        check_rows("recap", 8'd3, 8'd4, 8'd9, 8'd14, 8'd11, 8'd2, 8'd9);

        // Re-arm: drop activate, data retained, then new capture.
        cycle(1'b0);
        chk("rearm.done", {7'b0, done}, 8'h00);
        chk("rearm.a11", oa[0], 8'd3);
        set_all(8'h80, 8'h01);
        cycle(1'b1);
        chk("rearm2.done", {7'b0, done}, 8'h01);
        chk("rearm2.a11", oa[0], 8'h80);
        chk("rearm2.b33", ob[8], 8'h01);

        // Boundary values in successive requests.
        set_all(8'hFF, 8'hFF);
        cycle(1'b0);
        cycle(1'b1);
        chk("ff.a44", oa[15], 8'hFF);
        chk("ff.b11", ob[0], 8'hFF);
        set_all(8'h00, 8'h00);
        cycle(1'b0);
        cycle(1'b1);
        chk("zero.a44", oa[15], 8'h00);
        chk("zero.b11", ob[0], 8'h00);

        // Random traffic: random data every cycle, random activate level.
        for (int n = 0; n < 40; n++) begin
            set_random();
            cycle(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
